sdram_req_scheduler: RTL
========================

# sdram_req_scheduler

Weighted round-robin scheduler sharing the single SDRAM controller request interface between `PORTS` buffered Wishbone port front-ends, in the SDRAM clock domain. It replaces plain round robin with three grant classes: starved ports, priority ports, then everyone else. A per-port quota lets a granted port keep the controller for back-to-back transactions. It also gates grant changes on controller idle, so a switch never happens mid-transaction.

## Interface
- `PORTS`, 3: number of requesting ports (2..8)
- `QW`, 4: width of per-port quota field
- `AGE_LIMIT`, 64: cycles a requesting, ungranted port waits before it is marked starved
- `sdram_clk`  in  1  clock
- `sdram_rst_n`  in  1  asynchronous, active-low reset
- `req_acc_i`  in  PORTS  per-port access request; held until that port's transaction is done
- `req_we_i`  in  PORTS  per-port write flag
- `req_adr_i`  in  PORTS*32  per-port address, port p at [32p+31:32p]
- `req_dat_i`  in  PORTS*32  per-port write data
- `req_sel_i`  in  PORTS*4  per-port byte selects
- `req_buf_width_i`  in  PORTS*4  per-port burst buffer width
- `req_ack_o`  out  PORTS  per-port ack
- `prio_i`  in  PORTS  static high-priority flag per port
- `quota_i`  in  PORTS*QW  maximum consecutive transactions per grant; 0 is treated as 1
- `sdram_idle_i`  in  1  controller idle
- `ack_i`  in  1  controller ack
- `adr_o`, `dat_o`  out  32  muxed from the granted port
- `sel_o`, `buf_width_o`  out  4  muxed from the granted port
- `we_o`, `acc_o`  out  1  muxed from the granted port
- `grant_o`  out  PORTS  one-hot grant, registered
- `grant_valid_o`  out  1  high in BUSY and DRAIN

## Operation
- **State machine:** IDLE, BUSY, DRAIN. State is 2 bits, registered.
- **IDLE:**
  - If `sdram_idle_i` is high and any `req_acc_i` is high, arbitrate and go to BUSY.
  - `grant_o` is loaded with the winner and `txn_cnt` is cleared to 0.
- **BUSY:**
  - `acc_o = req_acc_i[g]`. `adr_o`, `dat_o`, `sel_o`, `we_o` and `buf_width_o` are driven from port g.
  - A falling edge of `req_acc_i[g]` (detected against a registered copy) increments `txn_cnt`, saturating at 2^QW-1, and moves the FSM to DRAIN.
- **DRAIN:**
  - `acc_o = 0`. Wait for `sdram_idle_i`.
  - Once idle, keep g (back to BUSY, `txn_cnt` kept) only if all of the following hold:
    - `req_acc_i[g]` is high;
    - `txn_cnt < eff_quota[g]`;
    - no other port is starved;
    - g has `prio_i` set, or no other priority port is requesting.
  - Otherwise re-arbitrate (next state BUSY, `txn_cnt` cleared). If no port is requesting, go to IDLE and clear `grant_o` to 0.
- **Arbitration classes:** the first non-empty set wins:
  1. starved ports that are requesting;
  2. requesting ports with `prio_i` set;
  3. all requesting ports.
- **Order within a class:** round robin starting at `last+1` mod PORTS. `last` is the index of the most recent grant, so the previous owner is picked last.
- **Age counters:** one per port, width clog2(AGE_LIMIT+1).
  - Increment when `req_acc_i[p]` is high and port p is not the current grant holder; saturate at AGE_LIMIT.
  - Clear on grant to p, or when `req_acc_i[p]` is low.
  - A port is starved when its count equals AGE_LIMIT.
- **Ack routing:** `req_ack_o[p] = ack_i & grant_o[p]`, in any state, so a late ack in DRAIN still reaches its owner.
- **Output muxes:** when `grant_o` is 0, every muxed output is 0.
- **Mid-operation reset:** asserting `sdram_rst_n` low forces IDLE immediately (asynchronously) and all outputs drop within that cycle.

## Timing
- **Reset values:**
  - `grant_o` = 0, `grant_valid_o` = 0, state IDLE;
  - `acc_o`, `we_o`, `adr_o`, `dat_o`, `sel_o`, `buf_width_o`, `req_ack_o` all 0;
  - `last` = PORTS-1, so port 0 wins the first tie; `txn_cnt` = 0; all age counters = 0.
- **Request to `acc_o`:** 1 cycle minimum (the IDLE decision is registered; `acc_o` is combinational from the granted request).
- **Transaction end to next `acc_o`:** at least 1 cycle of `acc_o` = 0 (DRAIN), plus however long the controller stays busy.
- **Simultaneous events:**
  - A new request arriving in the same cycle as the DRAIN decision is considered.
  - A port becoming starved in that cycle preempts the hold-over.
- `grant_o` changes only on the DRAIN→BUSY, IDLE→BUSY or DRAIN→IDLE transitions, and never while `acc_o` is 1.

## Test plan
- **Tie at reset:** all three ports request at once after reset, `quota_i` = 1 each, `prio_i` = 0 → grants go 0, 1, 2, 0, with an `acc_o` gap of at least 1 cycle between transactions.
- **Quota hold-over:** port 1 requests continuously with `quota_i[1]` = 3 while port 0 requests → port 1 gets 3 consecutive transactions, then port 0.
- **Priority preemption:** `prio_i` = 3'b100; ports 0 and 2 both request repeatedly, `quota_i` = 1 → port 2 wins every arbitration until port 0 reaches AGE_LIMIT=64 cycles of waiting, then port 0 gets exactly one grant.
- **Late ack in DRAIN:** `ack_i` pulses while the FSM is in DRAIN for port 1 → only `req_ack_o[1]` = 1; acks to the other ports stay 0.
- **Controller busy:** `sdram_idle_i` is held low for 10 cycles after port 0 ends its transaction → FSM stays in DRAIN, `acc_o` = 0 and `grant_o` is unchanged until idle returns.
- **Reset mid-transaction:** `sdram_rst_n` is pulled low in BUSY with `acc_o` = 1 → `acc_o`, `grant_o` and `grant_valid_o` are 0 in that same cycle; after release, port 0 wins the first tie again.

Source files
------------

// File: rtl/sdram_req_scheduler.sv
// Weighted round-robin scheduler for the shared SDRAM controller request port.
// Grant classes: starved ports, then priority ports, then everyone. A granted port
// may keep the controller for up to its quota of back-to-back transactions, and
// grants only change once the controller has gone idle.
module sdram_req_scheduler #(
  parameter int unsigned PORTS     = 3,
  parameter int unsigned QW        = 4,
  parameter int unsigned AGE_LIMIT = 64
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst_n,
  input  logic [PORTS-1:0]      req_acc_i,
  input  logic [PORTS-1:0]      req_we_i,
  input  logic [PORTS*32-1:0]   req_adr_i,
  input  logic [PORTS*32-1:0]   req_dat_i,
  input  logic [PORTS*4-1:0]    req_sel_i,
  input  logic [PORTS*4-1:0]    req_buf_width_i,
  output logic [PORTS-1:0]      req_ack_o,
  input  logic [PORTS-1:0]      prio_i,
  input  logic [PORTS*QW-1:0]   quota_i,
  input  logic                  sdram_idle_i,
  input  logic                  ack_i,
  output logic [31:0]           adr_o,
  output logic [31:0]           dat_o,
  output logic [3:0]            sel_o,
  output logic [3:0]            buf_width_o,
  output logic                  we_o,
  output logic                  acc_o,
  output logic [PORTS-1:0]      grant_o,
  output logic                  grant_valid_o
);

  localparam int unsigned IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [PORTS-1:0]          grant_q, grant_d;
  logic [IW-1:0]             last_q, last_d;
  logic [QW-1:0]             txn_cnt_q, txn_cnt_d;
  logic [PORTS-1:0]          req_acc_q;
  logic [PORTS-1:0][AW-1:0]  age_q, age_d;

  logic [PORTS-1:0]          starved;
  logic [PORTS-1:0]          cand;
  logic [PORTS-1:0]          win_onehot;
  logic [IW-1:0]             win_idx;
  logic                      win_found;
  logic                      grant_load;
  logic                      req_g, req_prev_g, prio_g, keep;
  logic [QW-1:0]             quota_g, eff_quota_g;

  // Class selection and round-robin pick starting just after the last grant
  always_comb begin
    int unsigned idx;
    idx        = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    for (int p = 0; p < PORTS; p++) begin
      starved[p] = (age_q[p] == AW'(AGE_LIMIT));
    end
    if ((starved & req_acc_i) != '0) begin
      cand = starved & req_acc_i;
    end else if ((prio_i & req_acc_i) != '0) begin
      cand = prio_i & req_acc_i;
    end else begin
      cand = req_acc_i;
    end
    for (int unsigned i = 1; i <= PORTS; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!win_found && cand[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
    win_onehot = {{(PORTS-1){1'b0}}, 1'b1} << win_idx;
  end

  // Hold-over qualification for the current owner
  always_comb begin
    quota_g = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_q[p]) quota_g = quota_g | quota_i[p*QW +: QW];
    end
    eff_quota_g = (quota_g == '0) ? QW'(1) : quota_g;
    req_g       = |(req_acc_i & grant_q);
    req_prev_g  = |(req_acc_q & grant_q);
    prio_g      = |(prio_i & grant_q);
    keep        = req_g && (txn_cnt_q < eff_quota_g)
                  && ((starved & req_acc_i & ~grant_q) == '0)
                  && (prio_g || ((prio_i & req_acc_i & ~grant_q) == '0));
  end

  // FSM next state, grant and transaction count
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    txn_cnt_d  = txn_cnt_q;
    grant_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sdram_idle_i && (req_acc_i != '0)) begin
          grant_load = 1'b1;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        // Owner dropping its request marks the end of one transaction
        if (req_prev_g && !req_g) begin
          state_d = StDrain;
          if (txn_cnt_q != '1) txn_cnt_d = txn_cnt_q + QW'(1);
        end
      end
      StDrain: begin
        if (sdram_idle_i) begin
          if (keep) begin
            state_d = StBusy;
          end else if (req_acc_i != '0) begin
            grant_load = 1'b1;
            state_d    = StBusy;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_load) begin
      grant_d   = win_onehot;
      last_d    = win_idx;
      txn_cnt_d = '0;
    end
  end

  // Per-port waiting age, cleared on grant or when the request goes away
  always_comb begin
    age_d = age_q;
    for (int p = 0; p < PORTS; p++) begin
      if (!req_acc_i[p] || (grant_load && win_onehot[p])) begin
        age_d[p] = '0;
      end else if (!grant_q[p] && (age_q[p] != AW'(AGE_LIMIT))) begin
        age_d[p] = age_q[p] + AW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= IW'(PORTS - 1);
      txn_cnt_q <= '0;
      req_acc_q <= '0;
      age_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      txn_cnt_q <= txn_cnt_d;
      req_acc_q <= req_acc_i;
      age_q     <= age_d;
    end
  end

  // Output muxes from the granted port; all zero when nothing is granted
  always_comb begin
    adr_o       = '0;
    dat_o       = '0;
    sel_o       = '0;
    buf_width_o = '0;
    we_o        = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_q[p]) begin
        adr_o       = adr_o | req_adr_i[p*32 +: 32];
        dat_o       = dat_o | req_dat_i[p*32 +: 32];
        sel_o       = sel_o | req_sel_i[p*4 +: 4];
        buf_width_o = buf_width_o | req_buf_width_i[p*4 +: 4];
        we_o        = we_o | req_we_i[p];
      end
    end
    acc_o         = (state_q == StBusy) && req_g;
    grant_o       = grant_q;
    grant_valid_o = (state_q != StIdle);
    // Ack follows the grant in any state so a late ack still reaches its owner
    req_ack_o     = {PORTS{ack_i}} & grant_q;
  end

endmodule
